alu_operand_entry: RTL and testbench

- Input-side counterpart to the ALU display path: turns raw slide switches and bouncy push-buttons into clean, stable operands for the ALU.
- Debounces four buttons and walks the user through a fixed entry sequence: Num1, then Num2, then Control.
- Issues the captured operand set to the ALU/display top with a valid/ready handshake, then drives the isResult selection for the display mux.
- Sits between the board I/O pins and the ALU top, replacing the direct switch and button wiring.

---
 rtl/alu_operand_entry.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_operand_entry.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_entry.sv
// Debounced button entry of Num1 -> Num2 -> Control, handed to the ALU top over a valid/ready handshake.
// Optional idle abandon of partial entry: define ENTRY_TIMEOUT_EN.
module alu_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [7:0] sw,
  input  logic       btn_next,
  input  logic       btn_back,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       op_ready,
  output logic [3:0] Num1,
  output logic [3:0] Num2,
  output logic [7:0] Control,
  output logic       M,
  output logic       isResult,
  output logic       op_valid,
  output logic [2:0] state
);

  localparam int unsigned DB_CYCLES = (DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES;
  localparam int unsigned CW        = $clog2(DB_CYCLES);

  localparam logic [2:0] S_A     = 3'd0;
  localparam logic [2:0] S_B     = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_SHOW  = 3'd4;

  // Button lanes: 0 next, 1 back, 2 clear, 3 mode
  logic [3:0]    raw_s;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d, stable_dly_q;
  logic [3:0]    pulse_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  assign raw_s = {btn_mode, btn_clear, btn_back, btn_next};

  // Debounce counters: accept a new level only after DB_CYCLES consecutive differing samples
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Synchronizers, debounced levels and rising-edge pulses
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q      <= 4'b0000;
      sync2_q      <= 4'b0000;
      stable_q     <= 4'b0000;
      stable_dly_q <= 4'b0000;
      pulse_q      <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= raw_s;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic next_p_s, back_p_s, clear_p_s, mode_p_s;
  assign next_p_s  = pulse_q[0];
  assign back_p_s  = pulse_q[1];
  assign clear_p_s = pulse_q[2];
  assign mode_p_s  = pulse_q[3];

  logic [2:0] state_q, state_d;
  logic [3:0] num1_q, num1_d, num2_q, num2_d;
  logic [7:0] control_q, control_d;
  logic       m_q, m_d, is_result_q, is_result_d, op_valid_q, op_valid_d;
  logic       timeout_s, clear_s;

  assign clear_s = clear_p_s | timeout_s;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          idle_state_s, any_pulse_s;

  assign idle_state_s = (state_q == S_B) || (state_q == S_OP);
  assign any_pulse_s  = |pulse_q;
  assign timeout_s    = idle_state_s && !any_pulse_s && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter restarts on any button activity or state change
  always_comb begin
    if (!idle_state_s || any_pulse_s || (state_d != state_q)) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + TW'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Entry FSM next state; clear outranks back, which outranks next
  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    control_d   = control_q;
    is_result_d = is_result_q;
    op_valid_d  = op_valid_q;
    if (clear_s) begin
      state_d     = S_A;
      num1_d      = 4'h0;
      num2_d      = 4'h0;
      control_d   = 8'h00;
      is_result_d = 1'b0;
      op_valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (next_p_s) begin
            num1_d  = sw[3:0];
            state_d = S_B;
          end else begin
            state_d = S_A;
          end
        end
        S_B: begin
          if (back_p_s) begin
            state_d = S_A;
          end else if (next_p_s) begin
            num2_d  = sw[3:0];
            state_d = S_OP;
          end else begin
            state_d = S_B;
          end
        end
        S_OP: begin
          if (back_p_s) begin
            state_d = S_B;
          end else if (next_p_s) begin
            control_d  = sw;
            op_valid_d = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_OP;
          end
        end
        S_ISSUE: begin
          if (back_p_s) begin
            op_valid_d = 1'b0;
            state_d    = S_OP;
          end else if (op_valid_q && op_ready) begin
            op_valid_d  = 1'b0;
            is_result_d = 1'b1;
            state_d     = S_SHOW;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_SHOW: begin
          if (back_p_s) begin
            is_result_d = 1'b0;
            state_d     = S_OP;
          end else if (next_p_s) begin
            is_result_d = 1'b0;
            state_d     = S_A;
          end else begin
            state_d = S_SHOW;
          end
        end
        default: begin
          state_d     = S_A;
          is_result_d = 1'b0;
          op_valid_d  = 1'b0;
        end
      endcase
    end
  end

  // Mode bit is independent of clear and frozen while the operand set is offered
  always_comb begin
    if (mode_p_s && ((state_q == S_A) || (state_q == S_B) ||
                     (state_q == S_OP) || (state_q == S_SHOW))) begin
      m_d = ~m_q;
    end else begin
      m_d = m_q;
    end
  end

  // FSM and operand registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_A;
      num1_q      <= 4'h0;
      num2_q      <= 4'h0;
      control_q   <= 8'h00;
      m_q         <= 1'b0;
      is_result_q <= 1'b0;
      op_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      control_q   <= control_d;
      m_q         <= m_d;
      is_result_q <= is_result_d;
      op_valid_q  <= op_valid_d;
    end
  end

  assign Num1     = num1_q;
  assign Num2     = num2_q;
  assign Control  = control_q;
  assign M        = m_q;
  assign isResult = is_result_q;
  assign op_valid = op_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed bench for alu_operand_entry with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_alu_operand_entry;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [7:0] sw;
  logic       btn_next, btn_back, btn_clear, btn_mode;
  logic       op_ready;
  logic [3:0] Num1, Num2;
  logic [7:0] Control;
  logic       M, isResult, op_valid;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  alu_operand_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .CLK(CLK), .RST_n(RST_n), .sw(sw),
    .btn_next(btn_next), .btn_back(btn_back), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .op_ready(op_ready),
    .Num1(Num1), .Num2(Num2), .Control(Control), .M(M),
    .isResult(isResult), .op_valid(op_valid), .state(state)
  );

  always #5 CLK = ~CLK;

  // mask bits: 0 next, 1 back, 2 clear, 3 mode
  task automatic press(input logic [3:0] mask);
    @(negedge CLK);
    {btn_mode, btn_clear, btn_back, btn_next} = mask;
    repeat (12) @(negedge CLK);
    {btn_mode, btn_clear, btn_back, btn_next} = 4'b0000;
    repeat (12) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_n = 1'b0; sw = 8'h00; op_ready = 1'b0;
    {btn_mode, btn_clear, btn_back, btn_next} = 4'b0000;
    repeat (3) @(negedge CLK);
    checks++;
    if ({Num1, Num2, Control, M, isResult, op_valid, state} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {Num1, Num2, Control, M, isResult, op_valid, state});
    end
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_bounce;
    sw = 8'h35;
    btn_next = 1'b1; @(negedge CLK);
    btn_next = 1'b0; @(negedge CLK);
    btn_next = 1'b1; @(negedge CLK);
    btn_next = 1'b0; @(negedge CLK);
    btn_next = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      checks++;
      if (state !== 3'd0) begin
        failures++;
        $display("FAIL bounce_early cycle=%0d got=%0d want=0", k, state);
      end
    end
    @(negedge CLK);
    checks++;
    if (state !== 3'd1 || Num1 !== 4'h5) begin
      failures++;
      $display("FAIL bounce_pulse got state=%0d Num1=%h want state=1 Num1=5", state, Num1);
    end
    btn_next = 1'b0;
    repeat (12) @(negedge CLK);
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL release_no_pulse got=%0d want=1", state);
    end
  endtask

  task automatic test_entry;
    sw = 8'h0C; press(4'b0001);
    checks++;
    if (state !== 3'd2 || Num2 !== 4'hC) begin
      failures++;
      $display("FAIL entry_num2 got state=%0d Num2=%h want 2/C", state, Num2);
    end
    sw = 8'h82; press(4'b0001);
    checks++;
    if (state !== 3'd3 || Control !== 8'h82 || op_valid !== 1'b1 || Num1 !== 4'h5 || Num2 !== 4'hC) begin
      failures++;
      $display("FAIL entry_issue got state=%0d ctl=%h v=%b n1=%h n2=%h want 3/82/1/5/C",
               state, Control, op_valid, Num1, Num2);
    end
  endtask

  task automatic test_handshake_stall;
    sw = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++;
      if ({op_valid, isResult, state, Num1, Num2, Control} !== {1'b1, 1'b0, 3'd3, 4'h5, 4'hC, 8'h82}) begin
        failures++;
        $display("FAIL stall_stable cycle=%0d got=%h", k, {op_valid, isResult, state, Num1, Num2, Control});
      end
    end
    op_ready = 1'b1;
    @(negedge CLK);
    op_ready = 1'b0;
    checks++;
    if (state !== 3'd4 || isResult !== 1'b1 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL transfer got state=%0d isResult=%b op_valid=%b want 4/1/0", state, isResult, op_valid);
    end
  endtask

  task automatic test_show_back;
    press(4'b0010);
    checks++;
    if (state !== 3'd2 || isResult !== 1'b0) begin
      failures++;
      $display("FAIL show_back got state=%0d isResult=%b want 2/0", state, isResult);
    end
    sw = 8'h82; press(4'b0001);
    checks++;
    if (state !== 3'd3 || op_valid !== 1'b1) begin
      failures++;
      $display("FAIL reissue got state=%0d op_valid=%b want 3/1", state, op_valid);
    end
  endtask

  task automatic test_issue_mode_back;
    press(4'b1000);
    checks++;
    if (M !== 1'b0 || state !== 3'd3) begin
      failures++;
      $display("FAIL issue_mode got M=%b state=%0d want 0/3", M, state);
    end
    press(4'b0011);
    checks++;
    if (state !== 3'd2 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL issue_back_wins got state=%0d op_valid=%b want 2/0", state, op_valid);
    end
  endtask

  task automatic test_mode_toggle;
    press(4'b1000);
    checks++;
    if (M !== 1'b1 || state !== 3'd2) begin
      failures++;
      $display("FAIL mode_toggle got M=%b state=%0d want 1/2", M, state);
    end
    sw = 8'h82; press(4'b0001);
    op_ready = 1'b1;
    @(negedge CLK);
    op_ready = 1'b0;
    checks++;
    if (state !== 3'd4 || isResult !== 1'b1) begin
      failures++;
      $display("FAIL second_transfer got state=%0d isResult=%b want 4/1", state, isResult);
    end
  endtask

  task automatic test_clear;
    press(4'b0101);
    checks++;
    if ({state, Num1, Num2, Control, isResult, op_valid, M} !== {3'd0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL clear_show got=%h want=%h", {state, Num1, Num2, Control, isResult, op_valid, M},
               {3'd0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_ready_idle;
    op_ready = 1'b1;
    repeat (5) @(negedge CLK);
    op_ready = 1'b0;
    checks++;
    if (state !== 3'd0 || op_valid !== 1'b0 || isResult !== 1'b0) begin
      failures++;
      $display("FAIL ready_no_valid got state=%0d v=%b r=%b want 0/0/0", state, op_valid, isResult);
    end
  endtask

  task automatic test_back_in_a;
    press(4'b0010);
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL back_in_a got=%0d want=0", state);
    end
    sw = 8'hA7; press(4'b0001);
    press(4'b0010);
    checks++;
    if (state !== 3'd0 || Num1 !== 4'h7) begin
      failures++;
      $display("FAIL back_keeps_num1 got state=%0d Num1=%h want 0/7", state, Num1);
    end
    press(4'b0001);
    checks++;
    if (state !== 3'd1 || Num1 !== 4'h7) begin
      failures++;
      $display("FAIL reenter_b got state=%0d Num1=%h want 1/7", state, Num1);
    end
  endtask

  task automatic test_timeout;
`ifdef ENTRY_TIMEOUT_EN
    repeat (60) @(negedge CLK);
    checks++;
    if (state !== 3'd0 || Num1 !== 4'h0 || M !== 1'b1) begin
      failures++;
      $display("FAIL timeout got state=%0d Num1=%h M=%b want 0/0/1", state, Num1, M);
    end
`else
    repeat (1000) @(negedge CLK);
    checks++;
    if (state !== 3'd1 || Num1 !== 4'h7) begin
      failures++;
      $display("FAIL no_timeout got state=%0d Num1=%h want 1/7", state, Num1);
    end
`endif
  endtask

  task automatic test_async_reset;
    press(4'b0001);
    sw = 8'h11; press(4'b0001);
    checks++;
    if (state !== 3'd3 || op_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_issue got state=%0d op_valid=%b want 3/1", state, op_valid);
    end
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if (op_valid !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL async_reset got op_valid=%b state=%0d want 0/0", op_valid, state);
    end
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_entry;
    test_handshake_stall;
    test_show_back;
    test_issue_mode_back;
    test_mode_toggle;
    test_clear;
    test_ready_idle;
    test_back_in_a;
    test_timeout;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
